ascon_ctrl_fsm: RTL and testbench
=================================

Name: ascon_ctrl_fsm

Overview:
Control state machine sitting directly upstream of the ASCON-128a permutation/XOR datapath; it drives every control input of that datapath (round counter, mux, register and XOR enables, cipher/tag captures). It sequences initialisation, one associated-data block, NB_PT_BLOCKS plaintext blocks and finalisation, one permutation round per clock. It also runs a valid/ready handshake with the block source feeding the datapath's 128-bit data input.

Parameters:
NB_PT_BLOCKS, 4, number of 128-bit plaintext blocks per message, including the last one; range 1..15.

Ports:
clock_i  in  1  clock
reset_i  in  1  reset; synchronous, active-high; all state and outputs cleared on the next rising edge
start_i  in  1  start a message; sampled only in IDLE
data_valid_i  in  1  source presents an AD/plaintext block on the datapath data input
data_ready_o  out  1  FSM waiting for a block; transfer = data_valid_i & data_ready_o
round_o  out  4  round index to the datapath
enable_o  out  1  state register write enable
sel_mux_o  out  1  0 = external initial state, 1 = feedback
ena_xor_up_o  out  1  XOR data into state words 0-1
ena_xor_down_o  out  1  enable end-of-permutation XOR
sel_xor_down_o  out  2  00: K into words 3-4; 01: domain bit into word 4; 10: K into words 2-3; 11: 01 and 10 combined
ena_cipher_o  out  1  capture cipher block
ena_tag_o  out  1  capture tag
block_idx_o  out  4  index of the current plaintext block, 0..NB_PT_BLOCKS-1
busy_o  out  1  high from the start cycle until the DONE cycle inclusive
done_o  out  1  one-cycle pulse; tag_o is valid from this cycle

Behaviour:
- Reset: state IDLE; all outputs 0, including round_o and block_idx_o. Reset mid-message aborts immediately; no tag or done.
- Outputs are combinational from state, round counter and data_valid_i. All defaults are 0 except sel_mux_o, which is 1 outside IDLE.
- IDLE, with start_i=1: round_o=0, sel_mux_o=0, enable_o=1; go to INIT with counter 1. start_i is ignored in all other states.
- INIT: rounds 1..11, enable_o=1. Round 11: ena_xor_down_o=1, sel=00. Then go to WAIT_AD.
- WAIT_AD: data_ready_o=1. On transfer, in the same cycle: round_o=4, ena_xor_up_o=1, enable_o=1; go to AD with counter 5. Without transfer: hold, enable_o=0.
- AD: rounds 5..11. Round 11: ena_xor_down_o=1, sel=01, or sel=11 if NB_PT_BLOCKS=1. Then go to WAIT_PT if NB_PT_BLOCKS>1, else WAIT_FIN.
- WAIT_PT: same handshake as WAIT_AD, plus ena_cipher_o=1 in the transfer cycle. Go to PT with counter 5.
- PT: rounds 5..11. Round 11: if block_idx_o = NB_PT_BLOCKS-2, assert ena_xor_down_o with sel=10. Then increment block_idx_o; go to WAIT_FIN if it now equals NB_PT_BLOCKS-1, else WAIT_PT.
- WAIT_FIN: handshake with round_o=0, ena_xor_up_o=1, ena_cipher_o=1, enable_o=1. Go to FIN with counter 1.
- FIN: rounds 1..11. Round 11: ena_xor_down_o=1, sel=00. Then go to TAG.
- TAG: one cycle, ena_tag_o=1, enable_o=0.
- DONE: one cycle, done_o=1. Then go to IDLE and clear block_idx_o.
- Data must be stable only in the transfer cycle. data_valid_i outside WAIT states is ignored.
- Latency with data_valid_i held high: 12 + 8·NB_PT_BLOCKS + 14 cycles from the start cycle to done_o inclusive.

Test Plan:
- NB_PT_BLOCKS=4, valid held high, start at cycle 0 -> INIT cycles 0-11; AD 12-19; PT blocks at 20, 28, 36; sel=10 xor-down at cycle 43; FIN 44-55; ena_tag_o at 56; done_o at 57; ena_cipher_o exactly at 20, 28, 36, 44.
- NB_PT_BLOCKS=1 -> sel_xor_down_o=11 at cycle 19; FIN 20-31; tag at 32; done at 33; no sel=10.
- Valid low for 5 cycles in WAIT_PT, block 1 -> data_ready_o=1, enable_o=0 and round_o frozen during the stall; handshake-cycle outputs match the no-stall case; total latency grows by 5.
- start_i pulsed during PT -> ignored; the sequence is unchanged.
- reset_i asserted at cycle 30 -> next cycle: IDLE, all outputs 0. A new start two cycles later completes normally with done_o at start+57.
- Full run against the datapath with a known-answer vector (key 000102..0F, nonce 000102..0F) -> cipher and tag match the ASCON-128a reference model.

Source files
------------

// File: rtl/ascon_ctrl_fsm.sv
// Control sequencer for the ASCON-128a permutation/XOR datapath.
// It runs init, one AD block, NB_PT_BLOCKS plaintext blocks and finalisation, one round per clock.
module ascon_ctrl_fsm #(
  parameter int NB_PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       enable_o,
  output logic       sel_mux_o,
  output logic       ena_xor_up_o,
  output logic       ena_xor_down_o,
  output logic [1:0] sel_xor_down_o,
  output logic       ena_cipher_o,
  output logic       ena_tag_o,
  output logic [3:0] block_idx_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_AD,
    S_AD,
    S_WAIT_PT,
    S_PT,
    S_WAIT_FIN,
    S_FIN,
    S_TAG,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_ROUND  = 4'd11;
  localparam logic [3:0] FIRST_INIT  = 4'd1;
  localparam logic [3:0] FIRST_BLOCK = 4'd5;
  localparam logic [3:0] XFER_ROUND  = 4'd4;
  localparam logic [3:0] LAST_BLK    = 4'(NB_PT_BLOCKS - 1);
  // Only meaningful when there are at least two plaintext blocks.
  localparam logic [3:0] PEN_BLK     = 4'(NB_PT_BLOCKS - 2);
  localparam bit         MULTI_BLK   = (NB_PT_BLOCKS > 1);

  state_t     state;
  logic [3:0] rnd_cnt;
  logic [3:0] blk_cnt;
  logic [3:0] blk_next;
  logic       last_round;

  assign blk_next   = blk_cnt + 4'd1;
  assign last_round = (rnd_cnt == LAST_ROUND);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state   <= S_IDLE;
      rnd_cnt <= 4'd0;
      blk_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state   <= S_INIT;
            rnd_cnt <= FIRST_INIT;
          end
        end
        S_INIT: begin
          if (last_round) state <= S_WAIT_AD;
          else            rnd_cnt <= rnd_cnt + 4'd1;
        end
        S_WAIT_AD: begin
          if (data_valid_i) begin
            state   <= S_AD;
            rnd_cnt <= FIRST_BLOCK;
          end
        end
        S_AD: begin
          if (last_round) state <= MULTI_BLK ? S_WAIT_PT : S_WAIT_FIN;
          else            rnd_cnt <= rnd_cnt + 4'd1;
        end
        S_WAIT_PT: begin
          if (data_valid_i) begin
            state   <= S_PT;
            rnd_cnt <= FIRST_BLOCK;
          end
        end
        S_PT: begin
          if (last_round) begin
            blk_cnt <= blk_next;
            state   <= (blk_next == LAST_BLK) ? S_WAIT_FIN : S_WAIT_PT;
          end else begin
            rnd_cnt <= rnd_cnt + 4'd1;
          end
        end
        S_WAIT_FIN: begin
          if (data_valid_i) begin
            state   <= S_FIN;
            rnd_cnt <= FIRST_INIT;
          end
        end
        S_FIN: begin
          if (last_round) state <= S_TAG;
          else            rnd_cnt <= rnd_cnt + 4'd1;
        end
        S_TAG: state <= S_DONE;
        S_DONE: begin
          state   <= S_IDLE;
          blk_cnt <= 4'd0;
        end
        default: begin
          state   <= S_IDLE;
          rnd_cnt <= 4'd0;
          blk_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Datapath controls are decoded combinationally so a handshake feeds the block in its transfer cycle.
  always_comb begin
    data_ready_o   = 1'b0;
    round_o        = 4'd0;
    enable_o       = 1'b0;
    sel_mux_o      = (state != S_IDLE);
    ena_xor_up_o   = 1'b0;
    ena_xor_down_o = 1'b0;
    sel_xor_down_o = 2'b00;
    ena_cipher_o   = 1'b0;
    ena_tag_o      = 1'b0;
    block_idx_o    = blk_cnt;
    busy_o         = (state != S_IDLE);
    done_o         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          enable_o = 1'b1;
          busy_o   = 1'b1;
        end
      end
      S_INIT, S_FIN: begin
        round_o  = rnd_cnt;
        enable_o = 1'b1;
        if (last_round) begin
          ena_xor_down_o = 1'b1;
          sel_xor_down_o = 2'b00;
        end
      end
      S_WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          round_o      = XFER_ROUND;
          ena_xor_up_o = 1'b1;
          enable_o     = 1'b1;
        end
      end
      S_AD: begin
        round_o  = rnd_cnt;
        enable_o = 1'b1;
        if (last_round) begin
          ena_xor_down_o = 1'b1;
          sel_xor_down_o = MULTI_BLK ? 2'b01 : 2'b11;
        end
      end
      S_WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          round_o      = XFER_ROUND;
          ena_xor_up_o = 1'b1;
          ena_cipher_o = 1'b1;
          enable_o     = 1'b1;
        end
      end
      S_PT: begin
        round_o  = rnd_cnt;
        enable_o = 1'b1;
        if (last_round && MULTI_BLK && (blk_cnt == PEN_BLK)) begin
          ena_xor_down_o = 1'b1;
          sel_xor_down_o = 2'b10;
        end
      end
      S_WAIT_FIN: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          ena_xor_up_o = 1'b1;
          ena_cipher_o = 1'b1;
          enable_o     = 1'b1;
        end
      end
      S_TAG:  ena_tag_o = 1'b1;
      S_DONE: done_o    = 1'b1;
      default: begin
        sel_mux_o = 1'b0;
        busy_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: three instances (4, 1 and 2 blocks); the expected trace of a
// message is built phase by phase, with random stalls and random ignored start/valid pulses.
module tb_ascon_ctrl_fsm;

  typedef struct packed {
    logic       ready;
    logic [3:0] round;
    logic       en;
    logic       mux;
    logic       xup;
    logic       xdn;
    logic [1:0] sel;
    logic       ciph;
    logic       tag;
    logic [3:0] blk;
    logic       busy;
    logic       done;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic valid;
  logic [1:0] cur;

  logic       rdy_a  [3];
  logic [3:0] rnd_a  [3];
  logic       en_a   [3];
  logic       mux_a  [3];
  logic       xup_a  [3];
  logic       xdn_a  [3];
  logic [1:0] sel_a  [3];
  logic       ciph_a [3];
  logic       tag_a  [3];
  logic [3:0] blk_a  [3];
  logic       busy_a [3];
  logic       done_a [3];

  vec_t obs;

  int compared    = 0;
  int mism        = 0;
  int cyc         = 0;
  int abort_at    = -1;
  bit aborted     = 1'b0;
  int done_seen   = -1;
  int total_stall = 0;
  int run_mode    = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NB = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
    ascon_ctrl_fsm #(.NB_PT_BLOCKS(NB)) u_dut (
      .clock_i        (clock),
      .reset_i        (reset),
      .start_i        (start && (cur == 2'(g))),
      .data_valid_i   (valid),
      .data_ready_o   (rdy_a[g]),
      .round_o        (rnd_a[g]),
      .enable_o       (en_a[g]),
      .sel_mux_o      (mux_a[g]),
      .ena_xor_up_o   (xup_a[g]),
      .ena_xor_down_o (xdn_a[g]),
      .sel_xor_down_o (sel_a[g]),
      .ena_cipher_o   (ciph_a[g]),
      .ena_tag_o      (tag_a[g]),
      .block_idx_o    (blk_a[g]),
      .busy_o         (busy_a[g]),
      .done_o         (done_a[g])
    );
  end

  always_comb begin
    obs       = '0;
    obs.ready = rdy_a[cur];
    obs.round = rnd_a[cur];
    obs.en    = en_a[cur];
    obs.mux   = mux_a[cur];
    obs.xup   = xup_a[cur];
    obs.xdn   = xdn_a[cur];
    obs.sel   = sel_a[cur];
    obs.ciph  = ciph_a[cur];
    obs.tag   = tag_a[cur];
    obs.blk   = blk_a[cur];
    obs.busy  = busy_a[cur];
    obs.done  = done_a[cur];
  end

  function automatic int nbOf(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4;
      2'd1:    return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic rstart();
    return ($urandom_range(0, 3) == 0);
  endfunction

  // Any cycle of a running message: state register loops back, busy, current block index.
  function automatic vec_t busyBase(input int blk);
    vec_t v;
    v      = '0;
    v.mux  = 1'b1;
    v.busy = 1'b1;
    v.blk  = 4'(blk);
    return v;
  endfunction

  task automatic applyStimulus(input logic st, input logic vd);
    start = st;
    valid = vd;
  endtask

  task automatic checkOutput(input vec_t exp, input string tag);
    compared++;
    if (obs.done && done_seen < 0) done_seen = cyc;
    assert (obs === exp) else begin
      mism++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: inputs go in just after the edge, outputs are compared before the next one.
  task automatic doStep(input logic st, input logic vd, input vec_t exp, input string tag);
    if (aborted) return;
    if (cyc == abort_at) begin
      reset = 1'b1;
      applyStimulus(1'b0, vd);
      @(posedge clock);
      #1;
      reset   = 1'b0;
      aborted = 1'b1;
      cyc++;
      return;
    end
    applyStimulus(st, vd);
    #3;
    checkOutput(exp, tag);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic rounds(input int first, input int blk, input logic xdn,
                        input logic [1:0] sel, input string tag);
    vec_t e;
    for (int r = first; r <= 11; r++) begin
      e       = busyBase(blk);
      e.round = 4'(r);
      e.en    = 1'b1;
      if (r == 11) begin
        e.xdn = xdn;
        e.sel = sel;
      end
      doStep(rstart(), rbit(), e, tag);
    end
  endtask

  // kind: 0 = AD block, 1 = plaintext block, 2 = final block.
  task automatic handshake(input int kind, input int blk, input int stalls, input string tag);
    vec_t e;
    for (int s = 0; s < stalls; s++) begin
      e       = busyBase(blk);
      e.ready = 1'b1;
      doStep(rstart(), 1'b0, e, {tag, "_stall"});
    end
    e       = busyBase(blk);
    e.ready = 1'b1;
    e.en    = 1'b1;
    e.xup   = 1'b1;
    e.round = (kind == 2) ? 4'd0 : 4'd4;
    e.ciph  = (kind != 0);
    total_stall += stalls;
    doStep(rstart(), 1'b1, e, {tag, "_xfer"});
  endtask

  // mode 0: source always valid; 1: five stall cycles before plaintext block 1; 2: random stalls.
  function automatic int stallsFor(input int kind, input int blk);
    if (run_mode == 1) return (kind == 1 && blk == 1) ? 5 : 0;
    if (run_mode == 2) return $urandom_range(0, 3);
    return 0;
  endfunction

  task automatic runMessage(input logic [1:0] idx, input int mode, input int abort_cyc);
    vec_t e;
    int nb;
    nb          = nbOf(idx);
    cur         = idx;
    run_mode    = mode;
    cyc         = 0;
    abort_at    = abort_cyc;
    aborted     = 1'b0;
    total_stall = 0;
    done_seen   = -1;
    e      = '0;
    e.busy = 1'b1;
    e.en   = 1'b1;
    doStep(1'b1, rbit(), e, "start");
    rounds(1, 0, 1'b1, 2'b00, "init");
    handshake(0, 0, stallsFor(0, 0), "ad");
    rounds(5, 0, 1'b1, (nb == 1) ? 2'b11 : 2'b01, "ad_round");
    for (int k = 0; k < nb - 1; k++) begin
      handshake(1, k, stallsFor(1, k), "pt");
      rounds(5, k, (k == nb - 2), (k == nb - 2) ? 2'b10 : 2'b00, "pt_round");
    end
    handshake(2, nb - 1, stallsFor(2, nb - 1), "fin");
    rounds(1, nb - 1, 1'b1, 2'b00, "fin_round");
    e     = busyBase(nb - 1);
    e.tag = 1'b1;
    doStep(rstart(), rbit(), e, "tag");
    e      = busyBase(nb - 1);
    e.done = 1'b1;
    doStep(rstart(), rbit(), e, "done");
    if (!aborted) begin
      compared++;
      assert (done_seen + 1 === 12 + 8 * nb + 14 + total_stall) else begin
        mism++;
        $error("[TB] FAIL latency nb=%0d observed=%0d expected=%0d",
               nb, done_seen + 1, 12 + 8 * nb + 14 + total_stall);
      end
    end
    doStep(1'b0, rbit(), '0, "idle_after");
  endtask

  initial begin
    reset = 1'b1;
    cur   = 2'd0;
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur = 2'(i);
      #1;
      checkOutput('0, "reset_state");
    end
    @(posedge clock);
    #1;

    $display("[TB] nominal runs, 4/1/2 blocks");
    runMessage(2'd0, 0, -1);
    runMessage(2'd1, 0, -1);
    runMessage(2'd2, 0, -1);

    $display("[TB] five-cycle stall before plaintext block 1");
    runMessage(2'd0, 1, -1);

    $display("[TB] reset at cycle 30, then a fresh message");
    runMessage(2'd0, 0, 30);
    aborted  = 1'b0;
    abort_at = -1;
    applyStimulus(1'b0, rbit());
    #3;
    checkOutput('0, "post_reset");
    @(posedge clock);
    #1;
    applyStimulus(1'b0, rbit());
    #3;
    checkOutput('0, "post_reset_idle");
    @(posedge clock);
    #1;
    runMessage(2'd0, 0, -1);

    $display("[TB] randomised runs");
    for (int n = 0; n < 8; n++) begin
      runMessage(2'($urandom_range(0, 2)), 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
